// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler.
package md_sched_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

  // HI/LO write bus: {hi_we, lo_we, hi, lo}
  function automatic int hilo_wd(input int w);
    return 2 + 2 * w;
  endfunction

endpackage

// File: rtl/md_operand_reg.sv
// Operand, sign and result capture registers for md_sched.
module md_operand_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load_op,
  input  logic         load_res,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         sign_in,
  input  logic [W-1:0] hi_in,
  input  logic [W-1:0] lo_in,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  output logic         sign_q,
  output logic [W-1:0] hi_q,
  output logic [W-1:0] lo_q
);

  // Capture operands on issue and results on completion; clear drops both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (clear) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (load_op) begin
        a_q    <= a_in;
        b_q    <= b_in;
        sign_q <= sign_in;
      end
      if (load_res) begin
        hi_q <= hi_in;
        lo_q <= lo_in;
      end
    end
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: launches the iterative units, holds EX stalled
// until the result is captured and presents one HI/LO write.
//
// state       | meaning
// ST_IDLE     | no operation in flight; MTHI/MTLO write straight through
// ST_MUL_WAIT | multiplier started, waiting for mul_ready
// ST_DIV_WAIT | divider started, waiting for div_ready
// ST_DONE     | result captured, HI/LO write presented until EX advances
module md_sched
  import md_sched_pkg::*;
#(
  parameter int W         = 32,
  parameter int DIV0_FAST = 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           req_valid,
  input  logic [2:0]     req_op,
  input  logic [W-1:0]   src_a,
  input  logic [W-1:0]   src_b,
  input  logic           stall_i,
  input  logic           flush,
  output logic           mul_start,
  output logic           mul_signed,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ready,
  input  logic [2*W-1:0] mul_result,
  output logic           div_start,
  output logic           div_signed,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  output logic           div_annul,
  input  logic           div_ready,
  input  logic [2*W-1:0] div_result,
  output logic           stallreq,
  output logic           hi_we,
  output logic           lo_we,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic           busy
);

  localparam int HILO_WD = hilo_wd(W);

  md_state_e state, state_nxt;

  logic               live, is_mul, is_div, sign_in;
  logic               load_op, load_res, clear;
  logic [W-1:0]       res_hi, res_lo;
  logic [W-1:0]       a_q, b_q, hi_q, lo_q;
  logic               sign_q;
  logic [HILO_WD-1:0] hilo_bus;

  // Gated by resetn so every output reads zero while reset is held.
  assign live    = resetn & req_valid;
  assign is_mul  = (req_op == MD_MULT) || (req_op == MD_MULTU);
  assign is_div  = (req_op == MD_DIV)  || (req_op == MD_DIVU);
  assign sign_in = (req_op == MD_MULT) || (req_op == MD_DIV);

  md_operand_reg #(.W(W)) u_opreg (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (clear),
    .load_op  (load_op),
    .load_res (load_res),
    .a_in     (src_a),
    .b_in     (src_b),
    .sign_in  (sign_in),
    .hi_in    (res_hi),
    .lo_in    (res_lo),
    .a_q      (a_q),
    .b_q      (b_q),
    .sign_q   (sign_q),
    .hi_q     (hi_q),
    .lo_q     (lo_q)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state, unit control, stall request and HI/LO write bus.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    stallreq  = 1'b0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    clear     = 1'b0;
    res_hi    = '0;
    res_lo    = '0;
    hilo_bus  = '0;
    case (state)
      ST_IDLE: begin
        if (live && !flush) begin
          if (is_mul) begin
            mul_start = 1'b1;
            stallreq  = 1'b1;
            load_op   = 1'b1;
            state_nxt = ST_MUL_WAIT;
          end else if (is_div) begin
            stallreq = 1'b1;
            if (DIV0_FAST != 0 && src_b == '0) begin
              load_res  = 1'b1;
              res_hi    = src_a;
              res_lo    = '1;
              state_nxt = ST_DONE;
            end else begin
              div_start = 1'b1;
              load_op   = 1'b1;
              state_nxt = ST_DIV_WAIT;
            end
          end else if (req_op == MD_MTHI) begin
            hilo_bus = {2'b10, src_a, {W{1'b0}}};
          end else if (req_op == MD_MTLO) begin
            hilo_bus = {2'b01, {W{1'b0}}, src_a};
          end
        end
      end
      ST_MUL_WAIT: begin
        stallreq = 1'b1;
        if (flush) begin
          clear     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (mul_ready) begin
          load_res  = 1'b1;
          res_hi    = mul_result[2*W-1:W];
          res_lo    = mul_result[W-1:0];
          state_nxt = ST_DONE;
        end
      end
      ST_DIV_WAIT: begin
        stallreq = 1'b1;
        if (flush) begin
          div_annul = 1'b1;
          clear     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (div_ready) begin
          load_res  = 1'b1;
          res_hi    = div_result[2*W-1:W];
          res_lo    = div_result[W-1:0];
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush) begin
          clear     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          hilo_bus = {2'b11, hi_q, lo_q};
          if (!stall_i) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands come straight from EX in the start cycle, then from the latches.
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    mul_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_signed = 1'b0;
    if (mul_start) begin
      mul_a      = src_a;
      mul_b      = src_b;
      mul_signed = sign_in;
    end else if (state == ST_MUL_WAIT) begin
      mul_a      = a_q;
      mul_b      = b_q;
      mul_signed = sign_q;
    end
    if (div_start) begin
      div_a      = src_a;
      div_b      = src_b;
      div_signed = sign_in;
    end else if (state == ST_DIV_WAIT) begin
      div_a      = a_q;
      div_b      = b_q;
      div_signed = sign_q;
    end
  end

  assign {hi_we, lo_we, hi_o, lo_o} = hilo_bus;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched with a transaction-level reference model.
module tb_md_sched;

  localparam int W = 32;
  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                         OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  logic clk, resetn;
  logic req_valid, stall_i, flush, mul_ready, div_ready;
  logic [2:0] req_op;
  logic [W-1:0] src_a, src_b;
  logic [2*W-1:0] mul_result, div_result;
  logic mul_start, mul_signed, div_start, div_signed, div_annul;
  logic stallreq, hi_we, lo_we, busy;
  logic [W-1:0] mul_a, mul_b, div_a, div_b, hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  md_sched #(.W(W), .DIV0_FAST(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .stall_i(stall_i), .flush(flush),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what is outstanding, and what result is being offered.
  int         m_pend;   // 0 nothing, 1 multiply outstanding, 2 divide outstanding
  logic       m_done;   // result held, write offered until EX advances
  logic [W-1:0] m_a, m_b, m_hi, m_lo;
  logic       m_sgn;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend <= 0; m_done <= 1'b0; m_a <= '0; m_b <= '0;
      m_sgn <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else if (m_done) begin
      if (flush || !stall_i) m_done <= 1'b0;
    end else if (m_pend != 0) begin
      if (flush) m_pend <= 0;
      else if (m_pend == 1 && mul_ready) begin
        m_pend <= 0; m_done <= 1'b1; {m_hi, m_lo} <= mul_result;
      end else if (m_pend == 2 && div_ready) begin
        m_pend <= 0; m_done <= 1'b1; {m_hi, m_lo} <= div_result;
      end
    end else if (req_valid && !flush) begin
      if (req_op == OP_MULT || req_op == OP_MULTU) begin
        m_pend <= 1; m_a <= src_a; m_b <= src_b; m_sgn <= (req_op == OP_MULT);
      end else if (req_op == OP_DIV || req_op == OP_DIVU) begin
        if (src_b == '0) begin
          m_done <= 1'b1; m_hi <= src_a; m_lo <= '1;
        end else begin
          m_pend <= 2; m_a <= src_a; m_b <= src_b; m_sgn <= (req_op == OP_DIV);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic e_ms, e_msg, e_ds, e_dsg, e_an, e_st, e_hwe, e_lwe, e_busy;
    logic [W-1:0] e_ma, e_mb, e_da, e_db, e_hi, e_lo;
    logic [200:0] exp_v, got_v;
    e_ms = 0; e_msg = 0; e_ds = 0; e_dsg = 0; e_an = 0; e_st = 0;
    e_hwe = 0; e_lwe = 0; e_busy = 0;
    e_ma = '0; e_mb = '0; e_da = '0; e_db = '0; e_hi = '0; e_lo = '0;
    if (!resetn) begin
      e_busy = 0;
    end else if (m_done) begin
      e_busy = 1;
      if (!flush) begin e_hwe = 1; e_lwe = 1; e_hi = m_hi; e_lo = m_lo; end
    end else if (m_pend != 0) begin
      e_busy = 1; e_st = 1;
      if (m_pend == 1) begin e_ma = m_a; e_mb = m_b; e_msg = m_sgn; end
      else begin e_da = m_a; e_db = m_b; e_dsg = m_sgn; e_an = flush; end
    end else if (req_valid && !flush) begin
      if (req_op == OP_MULT || req_op == OP_MULTU) begin
        e_ms = 1; e_st = 1; e_ma = src_a; e_mb = src_b; e_msg = (req_op == OP_MULT);
      end else if (req_op == OP_DIV || req_op == OP_DIVU) begin
        e_st = 1;
        if (src_b != '0) begin
          e_ds = 1; e_da = src_a; e_db = src_b; e_dsg = (req_op == OP_DIV);
        end
      end else if (req_op == OP_MTHI) begin
        e_hwe = 1; e_hi = src_a;
      end else if (req_op == OP_MTLO) begin
        e_lwe = 1; e_lo = src_a;
      end
    end
    exp_v = {e_ms, e_msg, e_ma, e_mb, e_ds, e_dsg, e_da, e_db, e_an, e_st,
             e_hwe, e_lwe, e_hi, e_lo, e_busy};
    got_v = {mul_start, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b,
             div_annul, stallreq, hi_we, lo_we, hi_o, lo_o, busy};
    if (chk_en) begin
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got_v, exp_v);
      end
    end
  end

  // Snapshot of the last cycle and event counters for the directed checks.
  logic s_ms, s_ds, s_an, s_st, s_hwe, s_lwe, s_busy;
  logic [W-1:0] s_hi, s_lo;
  int cnt_ms, cnt_ds, cnt_an, cnt_st, cnt_commit;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_ms = 0; cnt_ds = 0; cnt_an = 0; cnt_st = 0; cnt_commit = 0;
  endtask

  task automatic cyc(input logic rv, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic st, input logic fl,
                     input logic mr, input logic dr);
    req_valid = rv; req_op = op; src_a = a; src_b = b;
    stall_i = st; flush = fl; mul_ready = mr; div_ready = dr;
    @(negedge clk);
    #1;
    s_ms = mul_start; s_ds = div_start; s_an = div_annul; s_st = stallreq;
    s_hwe = hi_we; s_lwe = lo_we; s_hi = hi_o; s_lo = lo_o; s_busy = busy;
    cnt_ms += int'(mul_start); cnt_ds += int'(div_start); cnt_an += int'(div_annul);
    cnt_st += int'(stallreq);
    if (hi_we && lo_we && !stall_i) cnt_commit++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, OP_NONE, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    longint p;
    resetn = 1'b1; req_valid = 0; req_op = OP_NONE; src_a = '0; src_b = '0;
    stall_i = 0; flush = 0; mul_ready = 0; div_ready = 0;
    mul_result = '0; div_result = '0;
    clr_cnt();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;
    idle();
    chk("reset_busy", {63'b0, s_busy}, 64'd0);
    chk("reset_hilo", {s_hi, s_lo}, 64'd0);

    // MULT -3 * 5, multiplier latency 4
    a = 32'hFFFF_FFFD; b = 32'd5;
    p = longint'($signed(a)) * longint'($signed(b));
    mul_result = p;
    clr_cnt();
    cyc(1, OP_MULT, a, b, 0, 0, 0, 0);
    chk("mult_start", {63'b0, s_ms}, 64'd1);
    repeat (3) cyc(1, OP_MULT, a, b, 0, 0, 0, 0);
    cyc(1, OP_MULT, a, b, 0, 0, 1, 0);
    cyc(1, OP_MULT, a, b, 0, 0, 0, 0);
    chk("mult_done_data", {s_hi, s_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_done_stall", {63'b0, s_st}, 64'd0);
    idle();
    chk("mult_idle_busy", {63'b0, s_busy}, 64'd0);
    chk("mult_start_cnt", 64'(cnt_ms), 64'd1);
    chk("mult_stall_cnt", 64'(cnt_st), 64'd5);
    chk("mult_commit_cnt", 64'(cnt_commit), 64'd1);

    // DIVU 100 / 7
    a = 32'd100; b = 32'd7;
    div_result = {a % b, a / b};
    clr_cnt();
    cyc(1, OP_DIVU, a, b, 0, 0, 0, 0);
    repeat (2) cyc(1, OP_DIVU, a, b, 0, 0, 0, 0);
    cyc(1, OP_DIVU, a, b, 0, 0, 0, 1);
    cyc(1, OP_DIVU, a, b, 0, 0, 0, 0);
    chk("divu_done_data", {s_hi, s_lo}, {32'd2, 32'd14});
    chk("divu_done_stall", {63'b0, s_st}, 64'd0);
    idle();
    chk("divu_start_cnt", 64'(cnt_ds), 64'd1);

    // DIV by zero fast path
    clr_cnt();
    cyc(1, OP_DIV, 32'h0000_0055, '0, 0, 0, 0, 0);
    chk("div0_stall", {63'b0, s_st}, 64'd1);
    cyc(1, OP_DIV, 32'h0000_0055, '0, 0, 0, 0, 0);
    chk("div0_done_data", {s_hi, s_lo}, 64'h0000_0055_FFFF_FFFF);
    idle();
    chk("div0_start_cnt", 64'(cnt_ds), 64'd0);
    chk("div0_idle_busy", {63'b0, s_busy}, 64'd0);

    // MULTU 7*6, DONE held by stall_i for 3 cycles
    a = 32'd7; b = 32'd6;
    mul_result = {32'b0, a} * {32'b0, b};
    clr_cnt();
    cyc(1, OP_MULTU, a, b, 0, 0, 0, 0);
    cyc(1, OP_MULTU, a, b, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, OP_MULTU, a, b, 1, 0, 0, 0);
      chk("stall_done_lo", {31'b0, s_lwe, s_lo}, {31'b0, 1'b1, 32'd42});
    end
    cyc(1, OP_MULTU, a, b, 0, 0, 0, 0);
    idle();
    chk("stall_idle_busy", {63'b0, s_busy}, 64'd0);
    chk("stall_start_cnt", 64'(cnt_ms), 64'd1);
    chk("stall_commit_cnt", 64'(cnt_commit), 64'd1);

    // DIV flushed 10 cycles after start; late ready ignored
    a = 32'hFFFF_FFEC; b = 32'd3;
    div_result = 64'h0000_0002_0000_0006;
    clr_cnt();
    cyc(1, OP_DIV, a, b, 0, 0, 0, 0);
    repeat (9) cyc(1, OP_DIV, a, b, 0, 0, 0, 0);
    cyc(1, OP_DIV, a, b, 0, 1, 0, 0);
    chk("flush_annul", {63'b0, s_an}, 64'd1);
    chk("flush_no_we", {62'b0, s_hwe, s_lwe}, 64'd0);
    cyc(0, OP_NONE, '0, '0, 0, 0, 0, 1);
    chk("flush_idle_busy", {63'b0, s_busy}, 64'd0);
    idle();
    chk("flush_late_we", {62'b0, s_hwe, s_lwe}, 64'd0);
    chk("flush_annul_cnt", 64'(cnt_an), 64'd1);

    // MTLO, stray readies in IDLE, then async reset mid-multiply
    cyc(1, OP_MTLO, 32'h0000_1234, '0, 0, 0, 0, 0);
    chk("mtlo_we_data", {31'b0, s_lwe, s_lo}, {31'b0, 1'b1, 32'h0000_1234});
    chk("mtlo_stall_busy", {61'b0, s_st, s_busy, s_hwe}, 64'd0);
    cyc(0, OP_NONE, '0, '0, 0, 0, 1, 1);
    chk("stray_ready_busy", {63'b0, s_busy}, 64'd0);
    cyc(1, OP_MULT, 32'd9, 32'd9, 0, 0, 0, 0);
    cyc(1, OP_MULT, 32'd9, 32'd9, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_outs",
        {stallreq, mul_start, div_start, div_annul, hi_we, lo_we, busy, mul_signed, hi_o, lo_o},
        64'd0);
    chk("async_rst_ops", {mul_a, mul_b}, 64'd0);
    req_valid = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    idle();
    chk("post_rst_busy", {63'b0, s_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
